// File: rtl/match_monitor_pkg.sv
// Shared types and default widths for the match monitor.
// The widths are defaults only; every module re-exposes them as parameters.
package match_monitor_pkg;
    localparam int CNT_W  = 8;
    localparam int RUN_W  = 4;
    localparam int HIST_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        MATCH = 1'b1
    } state_t;
endpackage

// File: rtl/match_monitor_if.sv
// Detector input and statistics outputs of the match monitor.
// The producer of z/clear uses master; the monitor itself uses slave.
interface match_monitor_if #(
    parameter int CNT_W  = match_monitor_pkg::CNT_W,
    parameter int RUN_W  = match_monitor_pkg::RUN_W,
    parameter int HIST_W = match_monitor_pkg::HIST_W
) ();
    logic              z;
    logic              clear;
    logic [CNT_W-1:0]  count;
    logic [RUN_W-1:0]  run_len;
    logic [RUN_W-1:0]  max_run;
    logic [HIST_W-1:0] history;
    logic              active;

    modport master (output z, clear, input count, run_len, max_run, history, active);
    modport slave  (input z, clear, output count, run_len, max_run, history, active);
endinterface

// File: rtl/dff.sv
// Generic resettable register cell with a configurable reset value.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= RST_VAL;
        else       q <= d;
    end
endmodule

// File: rtl/match_monitor_sat_counter.sv
// Saturating up-counter. Priority: clr, then load1 (load the value 1), then inc.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;
    logic [W-1:0] w_nxt;

    always_comb begin
        w_nxt = r_q;
        if (clr)                     w_nxt = '0;
        else if (load1)              w_nxt = W'(1);
        else if (inc && r_q != '1)   w_nxt = r_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) r_q <= '0;
        else       r_q <= w_nxt;
    end

    assign o_q = r_q;
endmodule

// File: rtl/match_monitor.sv
// Statistics monitor for a sequence-detector output z: counts matches, tracks
// run lengths and the longest run, and keeps a short sample history.
module match_monitor #(
    parameter int CNT_W  = match_monitor_pkg::CNT_W,
    parameter int RUN_W  = match_monitor_pkg::RUN_W,
    parameter int HIST_W = match_monitor_pkg::HIST_W
) (
    input  logic           clk,
    input  logic           reset,
    match_monitor_if.slave bus
);
    import match_monitor_pkg::state_t;
    import match_monitor_pkg::IDLE;
    import match_monitor_pkg::MATCH;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [0:0]        w_state_bits;
    logic              w_rise;
    logic              w_run_inc;
    logic [CNT_W-1:0]  w_count;
    logic [RUN_W-1:0]  w_run;
    logic [RUN_W-1:0]  r_max_run;
    logic [HIST_W-1:0] r_history;

    dff #(.W(1), .RST_VAL(IDLE)) u_state (
        .clk   (clk),
        .reset (reset),
        .d     (w_state_nxt),
        .q     (w_state_bits)
    );
    assign r_state = state_t'(w_state_bits);

    // The state ignores clear so a match held across a clear is not recounted.
    always_comb begin
        w_state_nxt = IDLE;
        w_rise      = 1'b0;
        w_run_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                w_rise      = bus.z;
                w_state_nxt = bus.z ? MATCH : IDLE;
            end
            MATCH: begin
                w_run_inc   = bus.z;
                w_state_nxt = bus.z ? MATCH : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_count (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear),
        .load1 (1'b0),
        .inc   (w_rise),
        .o_q   (w_count)
    );

    sat_counter #(.W(RUN_W)) u_run (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear | ~bus.z),
        .load1 (w_rise),
        .inc   (w_run_inc),
        .o_q   (w_run)
    );

    // max_run never drops below run_len, so run_len can only overtake it by
    // starting a run from max_run==0 or by stepping past an equal max_run.
    always_ff @(posedge clk) begin
        if (reset || bus.clear)
            r_max_run <= '0;
        else if (w_rise && r_max_run == '0)
            r_max_run <= RUN_W'(1);
        else if (w_run_inc && w_run == r_max_run && w_run != '1)
            r_max_run <= w_run + RUN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) r_history <= '0;
        else       r_history <= {r_history[HIST_W-2:0], bus.z};
    end

    assign bus.count   = w_count;
    assign bus.run_len = w_run;
    assign bus.max_run = r_max_run;
    assign bus.history = r_history;
    assign bus.active  = (r_state == MATCH);
endmodule

// File: tb/tb_match_monitor.sv
// Self-checking bench for match_monitor: per-cycle model comparison plus
// hand-computed checkpoints for each scenario.
module tb_match_monitor;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    match_monitor_if bus ();

    match_monitor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: what each output must be after every sampled edge.
    bit        m_valid;
    bit        m_in_match;
    int        m_count;
    int        m_run;
    int        m_max;
    bit [7:0]  m_hist;

    always @(posedge clk) begin
        if (reset) begin
            m_valid    = 1'b1;
            m_in_match = 1'b0;
            m_count    = 0;
            m_run      = 0;
            m_max      = 0;
            m_hist     = 8'h00;
        end else if (m_valid) begin
            m_hist = {m_hist[6:0], bus.z};
            if (bus.clear) begin
                m_count = 0;
                m_run   = 0;
                m_max   = 0;
            end else begin
                if (bus.z && !m_in_match) m_count = (m_count >= 255) ? 255 : m_count + 1;
                if (!bus.z)               m_run = 0;
                else if (!m_in_match)     m_run = 1;
                else                      m_run = (m_run >= 15) ? 15 : m_run + 1;
                if (m_run > m_max) m_max = m_run;
            end
            m_in_match = bus.z;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model.count",   int'(bus.count),   m_count);
            check("model.run_len", int'(bus.run_len), m_run);
            check("model.max_run", int'(bus.max_run), m_max);
            check("model.history", int'(bus.history), int'(m_hist));
            check("model.active",  int'(bus.active),  int'(m_in_match));
        end
    end

    // Present inputs, then let one rising edge sample them; returns #1 after it.
    task automatic cyc(input bit zz, input bit cc);
        bus.z     = zz;
        bus.clear = cc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic expect_all(input string tag, input int c, input int r, input int mx, input int act);
        check({tag, ".count"},   int'(bus.count),   c);
        check({tag, ".run_len"}, int'(bus.run_len), r);
        check({tag, ".max_run"}, int'(bus.max_run), mx);
        check({tag, ".active"},  int'(bus.active),  act);
    endtask

    bit pat [7] = '{0, 1, 1, 1, 0, 1, 0};

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.z     = 1'b0;
        bus.clear = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        expect_all("reset", 0, 0, 0, 0);
        check("reset.history", int'(bus.history), 0);

        // Idle line
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        expect_all("idle", 0, 0, 0, 0);
        check("idle.history", int'(bus.history), 8'h00);

        // Two matches, longest run 3
        for (int i = 0; i < 7; i++) cyc(pat[i], 1'b0);
        expect_all("pattern", 2, 0, 3, 0);
        check("pattern.history", int'(bus.history), 8'h3A);

        // Long run saturates run_len and max_run
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
        expect_all("long_run", 1, 15, 15, 1);
        cyc(1'b0, 1'b0);
        expect_all("long_run_end", 1, 0, 15, 0);

        // Count saturation
        do_reset();
        for (int i = 0; i < 255; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
        check("sat255.count", int'(bus.count), 255);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
        check("sat260.count", int'(bus.count), 255);
        check("sat260.max_run", int'(bus.max_run), 1);

        // Clear in the middle of a held match
        do_reset();
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        expect_all("pre_clear", 1, 2, 2, 1);
        cyc(1'b1, 1'b1);
        expect_all("in_clear", 0, 0, 0, 1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        expect_all("post_clear", 0, 2, 2, 1);

        // Clear coinciding with a rising edge
        do_reset();
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        expect_all("clear_rise", 0, 0, 0, 1);
        cyc(1'b1, 1'b0);
        expect_all("clear_rise_next", 0, 1, 1, 1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        expect_all("clear_rise_new", 1, 1, 1, 1);

        // Reset aborts a match; z still high counts as a new rising edge
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        expect_all("pre_reset", 1, 3, 3, 1);
        reset = 1'b1;
        cyc(1'b1, 1'b1);
        expect_all("mid_reset", 0, 0, 0, 0);
        check("mid_reset.history", int'(bus.history), 0);
        reset = 1'b0;
        cyc(1'b1, 1'b0);
        expect_all("after_reset", 1, 1, 1, 1);
        check("after_reset.history", int'(bus.history), 8'h01);

        cyc(1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/match_monitor.md
MATCH_MONITOR -- requirements
Module: match_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the detection counter.
REQ-002 Parameter RUN_W, default 4: width of the run-length and maximum-run registers.
REQ-003 Parameter HIST_W, default 8: depth of the z history shift register.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 z  input  1  detector output from the upstream sequence FSM, already synchronous to clk.
REQ-007 clear  input  1  synchronous statistics clear, active-high.
REQ-008 count  output  CNT_W  number of z rising edges seen, saturating.
REQ-009 run_len  output  RUN_W  consecutive cycles z has been high in the current match, saturating.
REQ-010 max_run  output  RUN_W  largest run_len reached since the last reset or clear.
REQ-011 history  output  HIST_W  last HIST_W sampled z values; bit 0 is the newest.
REQ-012 active  output  1  high while the monitor is in state MATCH.

Function
REQ-013 All outputs SHALL be registered, with 1-cycle latency from a z sample to its effect.
REQ-014 Two states SHALL exist: IDLE and MATCH.
REQ-015 IDLE with z=1: go to MATCH, count+1 (saturating), run_len=1.
REQ-016 IDLE with z=0: stay in IDLE, run_len=0.
REQ-017 MATCH with z=1: stay in MATCH, run_len+1 (saturating at 2^RUN_W-1).
REQ-018 MATCH with z=0: go to IDLE, run_len=0; count unchanged.
REQ-019 count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 max_run SHALL load the next run_len on the same edge whenever the next run_len exceeds the current max_run.
REQ-021 history SHALL shift left by one bit every cycle, inserting z at bit 0, independent of clear.
REQ-022 active SHALL equal (state == MATCH).
REQ-023 When clear=1, count, run_len and max_run SHALL go to 0 and no increment occurs; the state still follows z per REQ-015..018.
REQ-024 If z is held high across a clear, the match SHALL NOT be recounted after clear deasserts; run_len SHALL resume from 1 on the first cycle after clear.
REQ-025 If clear and a rising edge of z coincide, the clear SHALL win: count=0, state=MATCH.

Reset
REQ-026 When reset=1 at a clk edge: state=IDLE, count=0, run_len=0, max_run=0, history=0, active=0.
REQ-027 reset SHALL take priority over clear and z.
REQ-028 Reset asserted mid-match SHALL abort the match; if z is still high on the first edge after reset deasserts, that edge SHALL count as a new rising edge.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, MATCH) and the default width constants CNT_W, RUN_W and HIST_W.
REQ-030 One sub-module, sat_counter, SHALL be used for count and run_len. It is parameterised by width and has ports clk, reset, clr, load1 and inc, and saturates at all-ones.
REQ-031 The state register SHALL be implemented with the codebase's dff cell, defaulting to IDLE.

Verification
REQ-032 Reset, then z=0 for 5 cycles -> count=0, run_len=0, active=0, history=8'h00.
REQ-033 z pattern 0,1,1,1,0,1,0 -> count=2, max_run=3, run_len=0, history=8'h3A one cycle after the last sample.
REQ-034 z held high for 20 cycles -> run_len and max_run stick at 15, count=1.
REQ-035 260 single-cycle z pulses separated by zeros -> count saturates at 255.
REQ-036 z high, clear pulsed on the 3rd cycle of the match, z stays high 2 more cycles -> count=0, run_len=2, max_run=2.
REQ-037 reset pulsed mid-match while z stays high -> all outputs 0 during reset; the first cycle after gives count=1, run_len=1, active=1.
